// File: rtl/bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bus_arbiter_pkg
// Purpose  : Shared types, select codes and round-robin helper for bus_arbiter3
// Revision : 1.0
// ============================================================================
package bus_arbiter_pkg;

    localparam int N_REQ = 3;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam logic [1:0] SEL_A    = 2'b00;
    localparam logic [1:0] SEL_B    = 2'b01;
    localparam logic [1:0] SEL_C    = 2'b10;
    localparam logic [1:0] SEL_NONE = 2'b11;

    // Scan from the farthest candidate (last) to the nearest (last+1) so the
    // nearest active request wins; SEL_NONE if nothing is requesting.
    function automatic logic [1:0] rr_pick(input logic [N_REQ-1:0] req,
                                           input logic [1:0]       last);
        logic [1:0] idx;
        rr_pick = SEL_NONE;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = 2'((int'(last) + k) % N_REQ);
            if (req[idx]) rr_pick = idx;
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/bus_arbiter3_if.sv
`default_nettype none
// ============================================================================
// Module   : bus_arbiter3_if
// Purpose  : Request/grant and result-bus signals of the three-way arbiter
// Revision : 1.0
// ============================================================================
interface bus_arbiter3_if;

    logic [2:0]  req;
    logic [15:0] A;
    logic [15:0] B;
    logic [15:0] C;
    logic [2:0]  gnt;
    logic [1:0]  sel;
    logic [15:0] Q;
    logic        bus_valid;
    logic        preempt;

    modport master (
        output req, A, B, C,
        input  gnt, sel, Q, bus_valid, preempt
    );

    modport slave (
        input  req, A, B, C,
        output gnt, sel, Q, bus_valid, preempt
    );

endinterface
`default_nettype wire

// File: rtl/multiplexer3to1.sv
`default_nettype none
// ============================================================================
// Module   : multiplexer3to1
// Purpose  : Plain 3-to-1 word multiplexer; the unused code falls back to a
// Revision : 1.0
// ============================================================================
module multiplexer3to1
    import bus_arbiter_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  wire logic [WIDTH-1:0] a,
    input  wire logic [WIDTH-1:0] b,
    input  wire logic [WIDTH-1:0] c,
    input  wire logic [1:0]       sel,
    output logic      [WIDTH-1:0] y
);

    always_comb begin
        y = a;
        case (sel)
            SEL_B:   y = b;
            SEL_C:   y = c;
            default: y = a;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/bus_arbiter3.sv
`default_nettype none
// ============================================================================
// Module   : bus_arbiter3
// Purpose  : Round-robin arbiter with hold limit for the shared result bus
// Revision : 1.0
// ============================================================================
module bus_arbiter3
    import bus_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 8
) (
    input  wire logic     clk,
    input  wire logic     rst,
    bus_arbiter3_if.slave bus
);

    localparam logic [CNT_W-1:0] C_HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    arb_state_t       state_q,     state_d;
    logic [1:0]       last_q,      last_d;
    logic [CNT_W-1:0] hold_cnt_q,  hold_cnt_d;
    logic [2:0]       gnt_q,       gnt_d;
    logic [1:0]       sel_q,       sel_d;
    logic             bus_valid_q, bus_valid_d;
    logic             preempt_q,   preempt_d;

    logic [1:0]       w_pick;
    logic [2:0]       w_others;
    logic [15:0]      w_mux_y;

    assign w_pick   = rr_pick(bus.req, last_q);
    assign w_others = bus.req & ~gnt_q;

    // In GRANT the owner is always last_q, so no separate owner register.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        hold_cnt_d  = hold_cnt_q;
        gnt_d       = gnt_q;
        sel_d       = sel_q;
        bus_valid_d = bus_valid_q;
        preempt_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    state_d     = GRANT;
                    last_d      = w_pick;
                    hold_cnt_d  = '0;
                    gnt_d       = 3'b001 << w_pick;
                    sel_d       = w_pick;
                    bus_valid_d = 1'b1;
                end
            end
            GRANT: begin
                if (!bus.req[last_q]) begin
                    state_d     = IDLE;
                    gnt_d       = 3'b000;
                    sel_d       = SEL_NONE;
                    bus_valid_d = 1'b0;
                end else if ((hold_cnt_q == C_HOLD_LAST) && (|w_others)) begin
                    state_d     = IDLE;
                    gnt_d       = 3'b000;
                    sel_d       = SEL_NONE;
                    bus_valid_d = 1'b0;
                    preempt_d   = 1'b1;
                end else if (hold_cnt_q != C_HOLD_LAST) begin
                    hold_cnt_d  = hold_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                gnt_d       = 3'b000;
                sel_d       = SEL_NONE;
                bus_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            last_q      <= SEL_C;
            hold_cnt_q  <= '0;
            gnt_q       <= 3'b000;
            sel_q       <= SEL_NONE;
            bus_valid_q <= 1'b0;
            preempt_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            hold_cnt_q  <= hold_cnt_d;
            gnt_q       <= gnt_d;
            sel_q       <= sel_d;
            bus_valid_q <= bus_valid_d;
            preempt_q   <= preempt_d;
        end
    end

    multiplexer3to1 #(
        .WIDTH (16)
    ) u_mux (
        .a   (bus.A),
        .b   (bus.B),
        .c   (bus.C),
        .sel (sel_q),
        .y   (w_mux_y)
    );

    assign bus.Q         = (sel_q == SEL_NONE) ? 16'h0000 : w_mux_y;
    assign bus.gnt       = gnt_q;
    assign bus.sel       = sel_q;
    assign bus.bus_valid = bus_valid_q;
    assign bus.preempt   = preempt_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter3.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_arbiter3
// Purpose  : Directed self-checking bench for bus_arbiter3 (MAX_HOLD 8 and 1)
// Revision : 1.0
// ============================================================================
module tb_bus_arbiter3;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    logic [15:0] dv [3];
    logic [2:0]  exp_gnt;
    logic [1:0]  exp_sel;
    logic [15:0] exp_q;
    logic        exp_pre;

    bus_arbiter3_if bus8 ();
    bus_arbiter3_if bus1 ();

    bus_arbiter3 #(.MAX_HOLD(8), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus8.slave)
    );

    bus_arbiter3 #(.MAX_HOLD(1), .CNT_W(8)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus8.req = 3'b000;
        bus1.req = 3'b000;
        step();
        rst = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        dv[0] = 16'hEEEE;
        dv[1] = 16'hBBBB;
        dv[2] = 16'hCCCC;
        bus8.A = dv[0]; bus8.B = dv[1]; bus8.C = dv[2];
        bus1.A = dv[0]; bus1.B = dv[1]; bus1.C = dv[2];
        bus8.req = 3'b000;
        bus1.req = 3'b000;
        rst = 1'b1;
        #1;
        chk("rst_gnt",   32'(bus8.gnt), 32'h0);
        chk("rst_sel",   32'(bus8.sel), 32'h3);
        chk("rst_valid", 32'(bus8.bus_valid), 32'h0);
        chk("rst_pre",   32'(bus8.preempt), 32'h0);
        chk("rst_q",     32'(bus8.Q), 32'h0);
        step();
        rst = 1'b0;

        // single request from A
        bus8.req = 3'b001;
        step();
        chk("a_gnt",   32'(bus8.gnt), 32'h1);
        chk("a_sel",   32'(bus8.sel), 32'h0);
        chk("a_q",     32'(bus8.Q), 32'hEEEE);
        chk("a_valid", 32'(bus8.bus_valid), 32'h1);
        bus8.req = 3'b000;
        step();
        chk("a_rel_gnt", 32'(bus8.gnt), 32'h0);
        chk("a_rel_sel", 32'(bus8.sel), 32'h3);

        // full contention: 8-cycle grants A,B,C,A,... with one idle cycle each
        do_reset();
        bus8.req = 3'b111;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (((k - 1) % 9) < 8) begin
                exp_gnt = 3'b001 << (((k - 1) / 9) % 3);
                exp_sel = 2'(((k - 1) / 9) % 3);
                exp_q   = dv[((k - 1) / 9) % 3];
                exp_pre = 1'b0;
            end else begin
                exp_gnt = 3'b000;
                exp_sel = 2'b11;
                exp_q   = 16'h0000;
                exp_pre = 1'b1;
            end
            chk($sformatf("rr_gnt_%0d", k), 32'(bus8.gnt), 32'(exp_gnt));
            chk($sformatf("rr_sel_%0d", k), 32'(bus8.sel), 32'(exp_sel));
            chk($sformatf("rr_q_%0d", k),   32'(bus8.Q),   32'(exp_q));
            chk($sformatf("rr_pre_%0d", k), 32'(bus8.preempt), 32'(exp_pre));
        end
        bus8.req = 3'b000;
        step();
        step();

        // lone B holds forever, counter saturates
        do_reset();
        bus8.req = 3'b010;
        for (int k = 1; k <= 30; k++) begin
            step();
            chk($sformatf("solo_gnt_%0d", k), 32'(bus8.gnt), 32'h2);
            chk($sformatf("solo_pre_%0d", k), 32'(bus8.preempt), 32'h0);
        end
        chk("solo_hold_sat", 32'(dut.hold_cnt_q), 32'd7);
        bus8.req = 3'b000;
        step();

        // last = B -> A granted; then A and C request together -> C first
        bus8.req = 3'b001;
        step();
        chk("ac_a_gnt", 32'(bus8.gnt), 32'h1);
        bus8.req = 3'b000;
        step();
        bus8.req = 3'b101;
        step();
        chk("ac_c_first", 32'(bus8.gnt), 32'h4);
        chk("ac_c_q",     32'(bus8.Q), 32'hCCCC);
        bus8.req = 3'b001;
        step();
        chk("ac_turn", 32'(bus8.gnt), 32'h0);
        step();
        chk("ac_a_next", 32'(bus8.gnt), 32'h1);

        // asynchronous reset in the middle of a C grant
        bus8.req = 3'b000;
        step();
        bus8.req = 3'b100;
        step();
        chk("mid_c_gnt", 32'(bus8.gnt), 32'h4);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_gnt",   32'(bus8.gnt), 32'h0);
        chk("mid_rst_sel",   32'(bus8.sel), 32'h3);
        chk("mid_rst_valid", 32'(bus8.bus_valid), 32'h0);
        step();
        rst = 1'b0;
        bus8.req = 3'b111;
        step();
        chk("post_rst_a", 32'(bus8.gnt), 32'h1);
        bus8.req = 3'b000;
        step();

        // A drops on its first granted cycle; pending B follows after one idle
        do_reset();
        bus8.req = 3'b011;
        step();
        chk("drop_a_gnt", 32'(bus8.gnt), 32'h1);
        bus8.req = 3'b010;
        step();
        chk("drop_idle", 32'(bus8.gnt), 32'h0);
        step();
        chk("drop_b_gnt",  32'(bus8.gnt), 32'h2);
        chk("drop_b_hold", 32'(dut.hold_cnt_q), 32'd0);
        bus8.req = 3'b000;
        step();

        // MAX_HOLD = 1 under contention: one grant cycle, one idle cycle
        do_reset();
        bus1.req = 3'b111;
        for (int k = 1; k <= 6; k++) begin
            step();
            if ((k % 2) == 1) begin
                exp_gnt = 3'b001 << ((k - 1) / 2);
                exp_pre = 1'b0;
            end else begin
                exp_gnt = 3'b000;
                exp_pre = 1'b1;
            end
            chk($sformatf("mh1_gnt_%0d", k), 32'(bus1.gnt), 32'(exp_gnt));
            chk($sformatf("mh1_pre_%0d", k), 32'(bus1.preempt), 32'(exp_pre));
        end
        bus1.req = 3'b000;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
